rl_out_packer: RTL and testbench
================================

Name: rl_out_packer

Overview:
- Downstream stage of the Riemann-Liouville fractional integrator.
- Detects each new integrator sample, signalled by a level toggle on the integrator's indicator output, and captures the 32-bit signed result into a small FIFO.
- Serialises each captured word MSB-first as bytes over a valid/ready stream, for a UART/host-link transmitter.
- Decouples the integrator's one-sample-per-toggle rate from a slower, back-pressured byte link.

Parameters:
- DATA_W, 32, width of the captured sample; fixed at 4 bytes per word.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 words.
- CNT_W, 16, width of the accepted-sample counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_data  in  DATA_W  signed integrator output, valid in the cycle in_toggle changes
- in_toggle  in  1  sample indicator; every level change is one new sample
- out_byte  out  8  current byte
- out_valid  out  1  out_byte valid
- out_ready  in  1  sink accepts the byte when out_valid&&out_ready at clk edge
- fifo_level  out  FIFO_AW+1  words currently stored in the FIFO (excludes the word in the shift register)
- overflow  out  1  sticky: a sample was dropped
- sample_count  out  CNT_W  accepted samples, wraps

Behaviour:
- Reset (rst==0 at posedge): out_valid=0, out_byte=0, fifo_level=0, overflow=0, sample_count=0, FSM=IDLE, byte_idx=0, FIFO pointers=0.
- During reset, prev_toggle<=in_toggle, so no spurious event occurs on release.
- Event: evt = (in_toggle != prev_toggle); prev_toggle updates every non-reset cycle.
- At most one event per cycle; the upstream toggles at most once per clk.
- Push: on evt, write in_data at the next edge.
- Push accepted if !full || pop_same_cycle. A simultaneous push+pop at full succeeds and the level is unchanged.
- Accepted push: sample_count+=1, wrapping.
- Rejected push (full, no pop): word dropped, overflow<=1. overflow clears only on reset.
- FSM IDLE: if FIFO non-empty, pop into a 32-bit shift register, byte_idx=0, go to SEND.
- FSM SEND: out_valid=1, out_byte=shift[31:24].
  - On out_ready: shift<<=8 and byte_idx+=1.
  - On acceptance of byte 3: if FIFO non-empty, pop the next word the same edge and stay in SEND (back-to-back, no bubble); else go to IDLE with out_valid=0.
- out_byte and out_valid are registered and hold stable while out_valid&&!out_ready.
- Latency: toggle at edge N → FIFO write at N+1 → pop at N+2 → out_valid=1 from N+2. With out_ready=1, one byte per clk thereafter.
- Capacity: 16 FIFO words + 1 in the shift register = 17 words in flight.
- Signed data is transmitted as its raw two's-complement bytes; no rescaling.
- Reset mid-frame: the partial frame is abandoned; the next frame after reset starts at byte 0.

Optional Feature:
- Macro RL_PACK_HDR_EN.
- Defined: each frame is preceded by sync byte 0xA5, giving 5 bytes/frame (HDR, B3, B2, B1, B0). The SEND phase starts with byte_idx=HDR; the back-to-back pop occurs after B0.
- Undefined: 4 bytes/frame, no header state in the FSM.

Decomposition:
- Shared package rl_pkg:
  - localparam RL_DATA_W=32
  - RL_SYNC_BYTE=8'hA5
  - FSM state encoding (IDLE, SEND)
  - byte index encoding
- One natural sub-module, rl_sync_fifo: parameterised DATA_W/AW, registered pointers, full/empty/level outputs, simultaneous push/pop at full supported.
- Toggle detect and serialiser FSM stay in rl_out_packer.

Test Plan:
- Single sample: in_data=0x12345678 with a toggle, out_ready=1 → out_valid rises 2 cycles later; bytes 12,34,56,78 on consecutive clks; then out_valid=0; sample_count=1.
- Backpressure: out_ready low for 5 cycles during byte 2 → out_byte holds 0x56 with out_valid=1; sequence resumes intact when out_ready rises.
- Overflow: out_ready=0, 18 toggles on consecutive clks → fifo_level=16, sample_count=17, overflow=1; draining yields exactly the first 17 words in order.
- Signed/back-to-back: words 0xFFFFFF80 then 0x00000001, out_ready=1 → FF,FF,FF,80,00,00,00,01 with no gap between frames.
- Reset mid-frame: rst=0 after byte 1 is accepted, with in_toggle held high → next cycle out_valid=0, fifo_level=0, overflow=0; no event on release; a new toggle yields a full 4-byte frame.
- RL_PACK_HDR_EN defined: sample 0x0000ABCD → A5,00,00,AB,CD.

Source files
------------

// File: rtl/rl_pkg.sv
// Shared definitions for the Riemann-Liouville output packer: word width,
// frame sync byte, serialiser FSM states and byte-position encoding.
package rl_pkg;

  localparam int RL_DATA_W = 32;
  localparam logic [7:0] RL_SYNC_BYTE = 8'hA5;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Frame byte positions in transmit order; the header slot is used only
  // when the sync-byte header is built in.
  typedef enum logic [2:0] {
    IDX_HDR = 3'd0,
    IDX_B3  = 3'd1,
    IDX_B2  = 3'd2,
    IDX_B1  = 3'd3,
    IDX_B0  = 3'd4
  } byte_idx_t;

endpackage

// File: rtl/rl_sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy counter. The
// read data is the current head word, and a pop makes room for a push in the
// same cycle, even when the FIFO is full.
module rl_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DATA_W-1:0] mem [2**AW];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full  = (level == DEPTH);
  assign empty = (level == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !rd_en) begin
        level <= level + 1'b1;
      end else if (!wr_en && rd_en) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rl_out_packer.sv
// Captures each integrator sample (one per in_toggle level change) into a FIFO
// and streams it MSB-first as bytes. Define RL_PACK_HDR_EN to prefix frames with 0xA5.
module rl_out_packer
  import rl_pkg::*;
#(
  parameter int DATA_W  = RL_DATA_W,
  parameter int FIFO_AW = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_toggle,
  output logic [7:0]         out_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic [CNT_W-1:0]   sample_count
);

`ifdef RL_PACK_HDR_EN
  localparam byte_idx_t FIRST_IDX = IDX_HDR;
`else
  localparam byte_idx_t FIRST_IDX = IDX_B3;
`endif

  logic              prev_toggle;
  logic              evt;
  logic              pop;
  logic              accept;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  state_t            state, state_n;
  byte_idx_t         byte_idx, byte_idx_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [7:0]        out_byte_n;
  logic              out_valid_n;

  // prev_toggle tracks in_toggle even in reset so release never looks like an event.
  always_ff @(posedge clk) begin
    prev_toggle <= in_toggle;
  end

  assign evt    = (in_toggle != prev_toggle);
  assign accept = evt && (!fifo_full || pop);

  rl_sync_fifo #(
    .DATA_W (DATA_W),
    .AW     (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt),
    .wdata (in_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      sample_count <= '0;
      overflow     <= 1'b0;
    end else begin
      if (accept) begin
        sample_count <= sample_count + 1'b1;
      end
      if (evt && !accept) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      byte_idx  <= IDX_HDR;
      shift     <= '0;
      out_byte  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      byte_idx  <= byte_idx_n;
      shift     <= shift_n;
      out_byte  <= out_byte_n;
      out_valid <= out_valid_n;
    end
  end

  // A pop always loads a fresh frame, so the load is applied after the case.
  always_comb begin
    state_n     = state;
    byte_idx_n  = byte_idx;
    shift_n     = shift;
    out_byte_n  = out_byte;
    out_valid_n = out_valid;
    pop         = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
        end
      end
      SEND: begin
        if (out_ready) begin
          case (byte_idx)
`ifdef RL_PACK_HDR_EN
            IDX_HDR: begin
              byte_idx_n = IDX_B3;
              out_byte_n = shift[DATA_W-1 -: 8];
            end
`endif
            IDX_B0: begin
              if (!fifo_empty) begin
                pop = 1'b1;
              end else begin
                state_n     = IDLE;
                out_valid_n = 1'b0;
              end
            end
            default: begin
              shift_n    = {shift[DATA_W-9:0], 8'h00};
              out_byte_n = shift[DATA_W-9 -: 8];
              byte_idx_n = byte_idx_t'(byte_idx + 3'd1);
            end
          endcase
        end
      end
      default: begin
        state_n     = IDLE;
        out_valid_n = 1'b0;
      end
    endcase

    if (pop) begin
      state_n     = SEND;
      shift_n     = fifo_rdata;
      byte_idx_n  = FIRST_IDX;
      out_valid_n = 1'b1;
`ifdef RL_PACK_HDR_EN
      out_byte_n  = RL_SYNC_BYTE;
`else
      out_byte_n  = fifo_rdata[DATA_W-1 -: 8];
`endif
    end
  end

endmodule

// File: tb/tb_rl_out_packer.sv
// Directed bench for rl_out_packer: latency, back-pressure, overflow, signed
// back-to-back frames and mid-frame reset. Expects headers when RL_PACK_HDR_EN is set.
module tb_rl_out_packer;

`ifdef RL_PACK_HDR_EN
  localparam int FRAME_BYTES = 5;
`else
  localparam int FRAME_BYTES = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_toggle = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [15:0] sample_count;

  int n_checks = 0;
  int n_fail   = 0;
  int waited;

  rl_out_packer dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_toggle    (in_toggle),
    .out_byte     (out_byte),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] expByte(input logic [31:0] w, input int i);
`ifdef RL_PACK_HDR_EN
    if (i == 0) return 8'hA5;
    return w[8*(4-i) +: 8];
`else
    return w[8*(3-i) +: 8];
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drives one sample at a falling edge and moves on to the next falling edge.
  task automatic applyStimulus(input logic [31:0] d);
    in_data   = d;
    in_toggle = ~in_toggle;
    @(negedge clk);
  endtask

  // Checks the byte on offer (waiting a bounded time for out_valid), then steps
  // past the edge that consumes it.
  task automatic recvByte(input string tag, input logic [7:0] exp, output int w);
    w = 0;
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput(tag, out_byte, exp);
    @(negedge clk);
  endtask

  task automatic recvFrame(input string tag, input logic [31:0] word, input bit no_gap);
    int w;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      recvByte($sformatf("%s_b%0d", tag, i), expByte(word, i), w);
      if (no_gap || i > 0) checkOutput($sformatf("%s_gap%0d", tag, i), w, 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_byte", out_byte, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_count", sample_count, 0);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("release_valid", out_valid, 0);
    checkOutput("release_count", sample_count, 0);

    // Single sample and its two-cycle latency
    out_ready = 1'b1;
    applyStimulus(32'h12345678);
    checkOutput("lat1_valid", out_valid, 0);
    checkOutput("lat1_level", fifo_level, 1);
    @(negedge clk);
    checkOutput("lat2_valid", out_valid, 1);
    checkOutput("lat2_level", fifo_level, 0);
    recvFrame("single", 32'h12345678, 1'b1);
    checkOutput("single_end_valid", out_valid, 0);
    checkOutput("single_count", sample_count, 1);

    // Back-pressure while 0x56 is on offer
    applyStimulus(32'h12345678);
    for (int i = 0; i < FRAME_BYTES - 2; i++) begin
      recvByte($sformatf("bp_b%0d", i), expByte(32'h12345678, i), waited);
    end
    checkOutput("bp_pre_byte", out_byte, 8'h56);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_hold_valid%0d", i), out_valid, 1);
      checkOutput($sformatf("bp_hold_byte%0d", i), out_byte, 8'h56);
    end
    out_ready = 1'b1;
    @(negedge clk);
    recvByte("bp_last", 8'h78, waited);
    checkOutput("bp_last_wait", waited, 0);
    checkOutput("bp_end_valid", out_valid, 0);
    checkOutput("bp_count", sample_count, 2);

    // Overflow: 18 samples into 17 slots with the link stalled
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) applyStimulus(32'h1000_0000 + i);
    checkOutput("ovf_pre_level", fifo_level, 16);
    checkOutput("ovf_pre_flag", overflow, 0);
    applyStimulus(32'h1000_0011);
    checkOutput("ovf_level", fifo_level, 16);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_count", sample_count, 19);
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) recvFrame($sformatf("drain%0d", i), 32'h1000_0000 + i, 1'b1);
    checkOutput("drain_end_valid", out_valid, 0);
    checkOutput("drain_level", fifo_level, 0);
    checkOutput("drain_ovf_sticky", overflow, 1);

    // Signed words back to back
    applyStimulus(32'hFFFF_FF80);
    applyStimulus(32'h0000_0001);
    recvFrame("neg", 32'hFFFF_FF80, 1'b1);
    recvFrame("pos", 32'h0000_0001, 1'b1);
    checkOutput("b2b_end_valid", out_valid, 0);
    checkOutput("b2b_count", sample_count, 21);

    // Reset after byte 1 of a frame, toggle left high
    applyStimulus(32'hDEAD_BEEF);
    recvByte("mid_b0", expByte(32'hDEAD_BEEF, 0), waited);
    recvByte("mid_b1", expByte(32'hDEAD_BEEF, 1), waited);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_byte", out_byte, 0);
    checkOutput("mid_rst_level", fifo_level, 0);
    checkOutput("mid_rst_ovf", overflow, 0);
    checkOutput("mid_rst_count", sample_count, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("mid_rel_valid", out_valid, 0);
    checkOutput("mid_rel_count", sample_count, 0);
    checkOutput("mid_rel_level", fifo_level, 0);
    applyStimulus(32'h0BAD_F00D);
    recvFrame("post_rst", 32'h0BAD_F00D, 1'b0);
    checkOutput("post_rst_end_valid", out_valid, 0);
    checkOutput("post_rst_count", sample_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
